// File: rtl/pri_pkg.sv
// Shared constants and width helper for the registered priority encoder/arbiter.
package pri_pkg;
  localparam logic PRI_MODE_FIXED = 1'b0;
  localparam logic PRI_MODE_RR    = 1'b1;

  function automatic int pri_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/pri_sel_n.sv
// Combinational selector: first set bit searching downward from start, wrapping N-1..start+1.
module pri_sel_n
  import pri_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = pri_idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);
  localparam int PW = IDX_W + 1;

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW-1:0]  pos;

  // Rotate so req[start] lands on the top bit; highest set bit of rot is then the winner.
  always_comb begin
    dbl = {req, req} >> (PW'(start) + PW'(1));
    rot = dbl[N-1:0];
    pos = '0;
    for (int j = 0; j < N; j++)
      if (rot[j]) pos = PW'(j);
    pos = pos + PW'(start) + PW'(1);
    if (pos >= PW'(N)) pos = pos - PW'(N);
    idx    = '0;
    onehot = '0;
    if (|req) begin
      idx    = pos[IDX_W-1:0];
      onehot = N'(1) << pos[IDX_W-1:0];
    end
  end
endmodule

// File: rtl/pri_encode_rr.sv
// Registered fixed-priority / round-robin arbiter with a valid/ready winner channel.
module pri_encode_rr
  import pri_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [N-1:0]            req,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [pri_idx_w(N)-1:0] out_idx,
  output logic [N-1:0]            out_onehot,
  output logic                    idc
);
  localparam int IDX_W = pri_idx_w(N);
  localparam logic [IDX_W-1:0] TOP = IDX_W'(N - 1);

  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [N-1:0]     out_onehot_q, out_onehot_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             idc_q, idc_d;

  logic             hs, slot_open, capture;
  logic [IDX_W-1:0] ptr_adv, ptr_eff, sel_start, sel_idx;
  logic [N-1:0]     sel_onehot;

  assign hs        = out_valid_q & out_ready;
  assign slot_open = ~out_valid_q | out_ready;
  assign capture   = slot_open & en & (|req);
  assign ptr_adv   = (out_idx_q == '0) ? TOP : out_idx_q - IDX_W'(1);
  // Accept-cycle capture already searches from the advanced pointer.
  assign ptr_eff   = hs ? ptr_adv : ptr_q;
  assign sel_start = (mode == PRI_MODE_RR) ? ptr_eff : TOP;

  pri_sel_n #(.N(N), .IDX_W(IDX_W)) u_sel (
    .req    (req),
    .start  (sel_start),
    .idx    (sel_idx),
    .onehot (sel_onehot)
  );

  always_comb begin
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_onehot_d = out_onehot_q;
    ptr_d        = hs ? ptr_adv : ptr_q;
    idc_d        = en & (|req);
    if (slot_open) begin
      out_valid_d  = capture;
      out_idx_d    = capture ? sel_idx : '0;
      out_onehot_d = capture ? sel_onehot : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_onehot_q <= '0;
      ptr_q        <= TOP;
      idc_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_onehot_q <= out_onehot_d;
      ptr_q        <= ptr_d;
      idc_q        <= idc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_onehot = out_onehot_q;
  assign idc        = idc_q;
endmodule
